// File: rtl/weight_col_loader.sv
// Write-side weight loader: takes a column-major valid/ready element stream, writes it to
// weight memory one cycle after acceptance, and flags each completed column and the full matrix.
module weight_col_loader #(
  parameter int WEIGHT_ROWS = 96,
  parameter int WEIGHT_COLS = 3,
  parameter int DATA_WIDTH  = 5,
  parameter int ROW_WIDTH   = $clog2(WEIGHT_ROWS),
  parameter int COL_WIDTH   = $clog2(WEIGHT_COLS),
  parameter int ADDR_WIDTH  = $clog2(WEIGHT_ROWS*WEIGHT_COLS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  col_done,
  output logic [COL_WIDTH-1:0]  col_done_idx,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [ROW_WIDTH-1:0]    row, row_next;
  logic [COL_WIDTH-1:0]    col, col_next;
  logic                    accept;
  logic                    last_row;
  logic                    last_col;
  logic [ADDR_WIDTH-1:0]   addr_cur;

  assign last_row = (row == ROW_WIDTH'(WEIGHT_ROWS - 1));
  assign last_col = (col == COL_WIDTH'(WEIGHT_COLS - 1));

  // Product formed at full address width so the top address cannot wrap.
  assign addr_cur = ADDR_WIDTH'(col) * ADDR_WIDTH'(WEIGHT_ROWS) + ADDR_WIDTH'(row);

  always_comb begin
    in_ready = (state == LOAD) && !abort;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    state_next = state;
    row_next   = row;
    col_next   = col;
    if (abort) begin
      state_next = IDLE;
      row_next   = '0;
      col_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_next = LOAD;
            row_next   = '0;
            col_next   = '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (last_row) begin
              row_next = '0;
              if (last_col) begin
                col_next   = '0;
                state_next = DONE;
              end else begin
                col_next = col + 1'b1;
              end
            end else begin
              row_next = row + 1'b1;
            end
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      col_done     <= 1'b0;
      col_done_idx <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state    <= state_next;
      row      <= row_next;
      col      <= col_next;
      busy     <= (state_next == LOAD);
      done     <= (state_next == DONE);
      wr_en    <= accept;
      col_done <= accept && last_row;
      if (accept) begin
        wr_addr <= addr_cur;
        wr_data <= in_data;
      end
      if (accept && last_row) begin
        col_done_idx <= col;
      end
    end
  end

endmodule

// File: tb/tb_weight_col_loader.sv
// Scoreboard bench for weight_col_loader: a small 4x3x8 instance with directed and random
// stimulus, plus a default-parameter instance streaming the full 96x3 matrix.
module tb_weight_col_loader;

  localparam int AR = 4;
  localparam int AC = 3;
  localparam int AN = AR * AC;
  localparam int BR = 96;
  localparam int BC = 3;
  localparam int BN = BR * BC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int stamp;
    int addr;
    int data;
    bit cd;
    int cdi;
    bit dn;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Small instance
  logic       start_a = 0, abort_a = 0, valid_a = 0;
  logic [7:0] data_a = '0;
  logic       ready_a, wr_en_a, col_done_a, busy_a, done_a;
  logic [3:0] wr_addr_a;
  logic [7:0] wr_data_a;
  logic [1:0] cdi_a;

  // Default-parameter instance
  logic       start_b = 0, abort_b = 0, valid_b = 0;
  logic [4:0] data_b = '0;
  logic       ready_b, wr_en_b, col_done_b, busy_b, done_b;
  logic [8:0] wr_addr_b;
  logic [4:0] wr_data_b;
  logic [1:0] cdi_b;

  weight_col_loader #(.WEIGHT_ROWS(AR), .WEIGHT_COLS(AC), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .in_valid(valid_a), .in_data(data_a), .in_ready(ready_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .col_done(col_done_a), .col_done_idx(cdi_a), .busy(busy_a), .done(done_a)
  );

  weight_col_loader dut_big (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .in_valid(valid_b), .in_data(data_b), .in_ready(ready_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .col_done(col_done_b), .col_done_idx(cdi_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitors: pop the scoreboard whenever a write appears
  int last_cdi_a = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_cdi_a = 0;
    end else begin
      if (wr_en_a) begin
        if (qa.size() == 0) begin
          check("a_unexpected_write", 32'(wr_addr_a), 32'hFFFF_FFFF);
        end else begin
          e = qa.pop_front();
          check("a_write_cycle", cyc, e.stamp);
          check("a_wr_addr", 32'(wr_addr_a), e.addr);
          check("a_wr_data", 32'(wr_data_a), e.data);
          check("a_col_done", 32'(col_done_a), 32'(e.cd));
          check("a_done", 32'(done_a), 32'(e.dn));
          if (e.cd) last_cdi_a = e.cdi;
        end
      end else begin
        check("a_col_done_no_write", 32'(col_done_a), 0);
        check("a_done_no_write", 32'(done_a), 0);
      end
      check("a_col_done_idx", 32'(cdi_a), last_cdi_a);
    end
  end

  int last_cdi_b = 0;
  int b_writes = 0;
  int b_dones = 0;
  int b_last_addr = -1;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_cdi_b = 0;
    end else begin
      if (done_b) b_dones++;
      if (wr_en_b) begin
        b_writes++;
        b_last_addr = int'(wr_addr_b);
        if (qb.size() == 0) begin
          check("b_unexpected_write", 32'(wr_addr_b), 32'hFFFF_FFFF);
        end else begin
          e = qb.pop_front();
          check("b_write_cycle", cyc, e.stamp);
          check("b_wr_addr", 32'(wr_addr_b), e.addr);
          check("b_wr_data", 32'(wr_data_b), e.data);
          check("b_col_done", 32'(col_done_b), 32'(e.cd));
          check("b_done", 32'(done_b), 32'(e.dn));
          if (e.cd) last_cdi_b = e.cdi;
        end
      end else begin
        check("b_col_done_no_write", 32'(col_done_b), 0);
        check("b_done_no_write", 32'(done_b), 0);
      end
      check("b_col_done_idx", 32'(cdi_b), last_cdi_b);
    end
  end

  // Reference model: a load is a count of accepted beats; element k lives at address k,
  // closes column k/R when k%R==R-1, and the last element finishes the matrix.
  bit a_loading = 0, a_done = 0;
  int a_pos = 0;

  task automatic step_a(input bit v, input logic [7:0] d, input bit st, input bit ab);
    bit was_done, acc;
    exp_t e;
    start_a = st; abort_a = ab; valid_a = v; data_a = d;
    #1;
    check("a_in_ready", 32'(ready_a), 32'(a_loading && !ab));
    check("a_busy", 32'(busy_a), 32'(a_loading));
    acc = v && a_loading && !ab;
    was_done = a_done;
    a_done = 0;
    if (ab) begin
      a_loading = 0;
      a_pos = 0;
    end else if (acc) begin
      e.stamp = cyc + 1; e.addr = a_pos; e.data = int'(d);
      e.cd = (a_pos % AR == AR - 1); e.cdi = a_pos / AR; e.dn = (a_pos == AN - 1);
      qa.push_back(e);
      a_pos++;
      if (a_pos == AN) begin
        a_pos = 0; a_loading = 0; a_done = 1;
      end
    end else if (st && !a_loading && !was_done) begin
      a_loading = 1;
      a_pos = 0;
    end
    @(negedge clk);
  endtask

  bit b_loading = 0;
  int b_pos = 0;

  task automatic step_b(input bit v, input logic [4:0] d, input bit st);
    bit acc;
    exp_t e;
    start_b = st; valid_b = v; data_b = d;
    #1;
    check("b_in_ready", 32'(ready_b), 32'(b_loading));
    acc = v && b_loading;
    if (acc) begin
      e.stamp = cyc + 1; e.addr = b_pos; e.data = int'(d);
      e.cd = (b_pos % BR == BR - 1); e.cdi = b_pos / BR; e.dn = (b_pos == BN - 1);
      qb.push_back(e);
      b_pos++;
      if (b_pos == BN) begin
        b_pos = 0; b_loading = 0;
      end
    end else if (st && !b_loading) begin
      b_loading = 1;
      b_pos = 0;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(ready_a), 0);
    check({tag, "_wr_en"}, 32'(wr_en_a), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr_a), 0);
    check({tag, "_wr_data"}, 32'(wr_data_a), 0);
    check({tag, "_col_done"}, 32'(col_done_a), 0);
    check({tag, "_col_done_idx"}, 32'(cdi_a), 0);
    check({tag, "_busy"}, 32'(busy_a), 0);
    check({tag, "_done"}, 32'(done_a), 0);
  endtask

  task automatic full_load_a(input int stall_mode);
    int n;
    step_a(0, 8'h00, 1, 0);
    n = 0;
    for (int k = 0; n < AN && k < 200; k++) begin
      bit v;
      v = (stall_mode == 0) ? 1'b1 : (k % 3 == 0);
      step_a(v, 8'(16 + n), 0, 0);
      if (v) n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    check_reset_outputs("reset");
    check("reset_b_wr_en", 32'(wr_en_b), 0);
    check("reset_b_busy", 32'(busy_b), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // In_valid while idle must not be accepted
    for (int i = 0; i < 3; i++) step_a(1, 8'($urandom), 0, 0);

    // Back-to-back load, then start during the DONE cycle is ignored
    full_load_a(0);
    step_a(1, 8'hAA, 1, 0);
    for (int i = 0; i < 3; i++) step_a(1, 8'hBB, 0, 0);

    // Stalled stream 1,0,0,1,...
    full_load_a(1);
    for (int i = 0; i < 3; i++) step_a(0, 8'h00, 0, 0);

    // Start pulsed mid-load
    step_a(0, 8'h00, 1, 0);
    for (int i = 0; i < AN; i++) step_a(1, 8'(32 + i), (i == 5), 0);
    for (int i = 0; i < 2; i++) step_a(0, 8'h00, 0, 0);

    // Abort after 6 beats, with in_valid high in the abort cycle
    step_a(0, 8'h00, 1, 0);
    for (int i = 0; i < 6; i++) step_a(1, 8'(48 + i), 0, 0);
    step_a(1, 8'hEE, 1, 1);
    for (int i = 0; i < 2; i++) step_a(1, 8'hEF, 0, 0);
    full_load_a(0);
    for (int i = 0; i < 2; i++) step_a(0, 8'h00, 0, 0);

    // Random valid, data, start and abort
    for (int i = 0; i < 400; i++) begin
      step_a(($urandom_range(0, 3) != 0), 8'($urandom),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0));
    end
    step_a(0, 8'h00, 0, 1);
    step_a(0, 8'h00, 0, 0);

    // Async reset between edges mid-column, then a clean reload
    step_a(0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) step_a(1, 8'(64 + i), 0, 0);
    step_a(0, 8'h00, 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    check("async_reset_pending", qa.size(), 0);
    a_loading = 0; a_done = 0; a_pos = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    full_load_a(0);
    for (int i = 0; i < 3; i++) step_a(0, 8'h00, 0, 0);

    // Full 96x3 matrix on the default-parameter instance
    b_writes = 0; b_dones = 0;
    step_b(0, 5'd0, 1);
    begin
      int n;
      n = 0;
      for (int k = 0; n < BN && k < 5000; k++) begin
        bit v;
        v = ($urandom_range(0, 3) != 0);
        if (v && b_loading) n++;
        step_b(v, 5'($urandom), 0);
      end
    end
    for (int i = 0; i < 4; i++) step_b(1, 5'd1, 0);

    check("a_scoreboard_empty", qa.size(), 0);
    check("b_scoreboard_empty", qb.size(), 0);
    check("b_write_count", b_writes, BN);
    check("b_last_addr", b_last_addr, BN - 1);
    check("b_done_count", b_dones, 1);
    check("b_final_col_done_idx", 32'(cdi_b), BC - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_col_loader.md
Name: weight_col_loader

Overview:
- Write-side counterpart to the weight-column read counter in the GCN datapath.
- Accepts a valid/ready stream of weight elements and writes them column-major into the weight memory.
- Flags each completed column so the read side can start consuming that column index.
- Raises a done pulse when the full WEIGHT_ROWS x WEIGHT_COLS matrix is resident.

Parameters:
- WEIGHT_ROWS, 96, rows per weight column (feature dimension).
- WEIGHT_COLS, 3, number of weight columns; must match the read-side column counter.
- DATA_WIDTH, 5, bits per weight element.
- ROW_WIDTH, $clog2(WEIGHT_ROWS), row counter width.
- COL_WIDTH, $clog2(WEIGHT_COLS), column counter width; same as the read-side counter width.
- ADDR_WIDTH, $clog2(WEIGHT_ROWS*WEIGHT_COLS), weight memory address width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a load; honoured only in IDLE.
- abort  input  1  synchronous abort; returns the block to IDLE from any state.
- in_valid  input  1  in_data is valid.
- in_data  input  DATA_WIDTH  weight element, column-major order (row 0..R-1 of col 0, then col 1, ...).
- in_ready  output  1  block accepts in_data this cycle.
- wr_en  output  1  weight memory write strobe.
- wr_addr  output  ADDR_WIDTH  write address = col*WEIGHT_ROWS + row.
- wr_data  output  DATA_WIDTH  write data.
- col_done  output  1  one-cycle pulse: column col_done_idx fully written.
- col_done_idx  output  COL_WIDTH  index of the completed column.
- busy  output  1  state is LOAD.
- done  output  1  one-cycle pulse: whole matrix written.

Behaviour:
- Reset (async, active-high) drives all outputs to 0: in_ready, wr_en, wr_addr, wr_data, col_done, col_done_idx, busy, done. Counters are zeroed and state is IDLE.
- States:
  - IDLE: start -> LOAD, with row and col cleared to 0.
  - LOAD: on the last beat accepted -> DONE.
  - DONE: lasts exactly 1 cycle, then -> IDLE.
- in_ready is combinational = (state==LOAD) && !abort. busy = (state==LOAD), registered with state.
- Accept = in_valid && in_ready. Non-accepted cycles change nothing; in_valid may stall arbitrarily.
- Write latency is 1 cycle. A beat accepted at cycle T produces, at T+1:
  - wr_en=1;
  - wr_data = the accepted element;
  - wr_addr = col*WEIGHT_ROWS + row, using the counter values at T.
  - With no accept at T, wr_en=0 at T+1; wr_addr and wr_data hold their previous values.
- Counters advance only on accept:
  - row==WEIGHT_ROWS-1 -> row wraps to 0 and col increments;
  - otherwise row increments.
  - Counters never exceed their bounds.
- col_done pulses at T+1 when the beat accepted at T had row==WEIGHT_ROWS-1. col_done_idx = that beat's col, held until the next col_done.
- Last beat (row==WEIGHT_ROWS-1, col==WEIGHT_COLS-1) accepted at T. At T+1, all of the following hold together:
  - wr_en=1;
  - col_done=1 with col_done_idx=WEIGHT_COLS-1;
  - state=DONE and done=1;
  - in_ready=0.
- At T+2 state=IDLE and done=0. Counters are left at 0 (wrapped).
- start in LOAD or DONE is ignored. start in the same cycle as abort is ignored (abort wins).
- abort in any state: next cycle state=IDLE, counters=0, wr_en=0, col_done=0, done=0. No beat is accepted in the abort cycle.
- Async reset mid-load gives an immediate return to reset values. Partial memory contents are not scrubbed.
- The address product is computed at ADDR_WIDTH width. The maximum address WEIGHT_ROWS*WEIGHT_COLS-1 must not overflow.

Test Plan:
- Full load (ROWS=4, COLS=3, DATA_WIDTH=8): start, then 12 back-to-back beats with data 0x10..0x1B.
  - wr_addr 0..11 with wr_data 0x10..0x1B, each 1 cycle after its accept.
  - col_done pulses with idx 0, 1, 2 after beats 4, 8, 12.
  - done=1 exactly 1 cycle after beat 12, then IDLE with in_ready=0.
- Stalled stream: same load with in_valid toggling 1,0,0,1,...
  - Identical write sequence; wr_en=0 on bubble cycles; counters unchanged during bubbles.
- Ignored start: in_valid=1 while IDLE -> in_ready=0, no wr_en. Pulse start mid-LOAD -> row and col unaffected; the sequence completes at 12 writes.
- Abort after 6 beats (col=1, row=2):
  - Next cycle IDLE, busy=0, no further wr_en.
  - New start plus 12 beats restarts at wr_addr 0.
- Async reset asserted mid-column (between clock edges) -> all outputs 0 immediately. After release, start reloads from address 0.
- Default params (96x3): stream 288 beats -> last wr_addr=287, col_done_idx=2, done pulse once; no address or counter wrap beyond bounds.
